hamming_encoder_stream: RTL and testbench



---
 rtl/hamming_encoder_stream_pkg.sv | 51 +++++
 rtl/hamming_encoder_stream_if.sv | 32 +++
 rtl/hamming_encoder_stream_fifo2.sv | 75 +++++++
 rtl/hamming_encoder_stream.sv | 90 +++++++++
 tb/tb_hamming_encoder_stream.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hamming_encoder_stream_pkg.sv
// -----------------------------------------------------------------------------
// hamming_pkg
// Shared Hamming(12,8) definitions for the encoder and decoder side of the
// protected image buffer.
//   - DATA_W / CODE_W / STORE_W : byte width, used codeword width, stored width
//   - PARITY_POS / DATA_POS     : codeword bit index of each parity / data bit
//                                 (bit index i corresponds to Hamming position i+1)
//   - P*_MASK                   : data bits covered by each even-parity bit
//   - fifo_entry_t              : one output buffer entry {last, codeword}
//   - hamming_encode12()        : byte -> 12-bit codeword
// -----------------------------------------------------------------------------
package hamming_pkg;

  localparam int DATA_W  = 8;
  localparam int CODE_W  = 12;
  localparam int STORE_W = 16;

  localparam int PARITY_POS [4] = '{0, 1, 3, 7};
  localparam int DATA_POS   [8] = '{2, 4, 5, 6, 8, 9, 10, 11};

  // p0 = d0^d1^d3^d4^d6, p1 = d0^d2^d3^d5^d6, p2 = d1^d2^d3^d7, p3 = d4^d5^d6^d7
  localparam logic [DATA_W-1:0] P0_MASK = 8'h5B;
  localparam logic [DATA_W-1:0] P1_MASK = 8'h6D;
  localparam logic [DATA_W-1:0] P2_MASK = 8'h8E;
  localparam logic [DATA_W-1:0] P3_MASK = 8'hF0;

  typedef logic [STORE_W-1:0] codeword_t;

  typedef struct packed {
    logic      last;
    codeword_t code;
  } fifo_entry_t;

  function automatic logic [CODE_W-1:0] hamming_encode12(input logic [DATA_W-1:0] data);
    logic [CODE_W-1:0] cw;
    logic [3:0]        par;
    cw = '0;
    for (int i = 0; i < DATA_W; i++) begin
      cw[DATA_POS[i]] = data[i];
    end
    par[0] = ^(data & P0_MASK);
    par[1] = ^(data & P1_MASK);
    par[2] = ^(data & P2_MASK);
    par[3] = ^(data & P3_MASK);
    for (int j = 0; j < 4; j++) begin
      cw[PARITY_POS[j]] = par[j];
    end
    return cw;
  endfunction

endpackage

// File: rtl/hamming_encoder_stream_if.sv
// -----------------------------------------------------------------------------
// hamming_encoder_stream_if
// Byte-in / codeword-out stream bundle of the Hamming encoder.
//   in_valid/in_ready/in_data/in_last : input byte handshake plus frame marker
//   inj_en/inj_pos                    : per-byte single-bit fault injection
//   out_valid/out_ready/out_data/out_last : codeword handshake plus frame marker
// master = producer of bytes / consumer of codewords, slave = the encoder.
// -----------------------------------------------------------------------------
interface hamming_encoder_stream_if;

  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        inj_en;
  logic [3:0]  inj_pos;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;

  modport master (
    output in_valid, in_data, in_last, inj_en, inj_pos, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, inj_en, inj_pos, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/hamming_encoder_stream_fifo2.sv
// -----------------------------------------------------------------------------
// hamming_fifo2
// Small synchronous FIFO holding {last, codeword} entries (used with DEPTH=2).
//   clk, rst_n    : clock, asynchronous active-low reset (clears contents)
//   push/push_data: write an entry (ignored when full)
//   pop           : drop the head entry (ignored when empty)
//   head          : current head entry, stable until popped
//   occupancy     : number of stored entries, 0..DEPTH
//   full/empty    : occupancy flags decoded from the occupancy register
// -----------------------------------------------------------------------------
module hamming_fifo2
  import hamming_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fifo_entry_t              push_data,
  input  logic                     pop,
  output fifo_entry_t              head,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  fifo_entry_t   mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   occ_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (occ_reg == (AW+1)'(DEPTH));
  assign empty   = (occ_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_reg[gi] <= '0;
        end else if (do_push && (wr_ptr_reg == AW'(gi))) begin
          mem_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   occ_reg <= occ_reg + (AW+1)'(1);
        2'b01:   occ_reg <= occ_reg - (AW+1)'(1);
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  assign head      = mem_reg[rd_ptr_reg];
  assign occupancy = occ_reg;

endmodule

// File: rtl/hamming_encoder_stream.sv
// -----------------------------------------------------------------------------
// hamming_encoder_stream
// Streaming Hamming(12,8) encoder: bytes in, 16-bit codewords out ([15:12]=0),
// optional single-bit fault injection, 2-entry output buffer, and a saturating
// count of delivered codewords.
//   clk, rst_n : clock, asynchronous active-low reset
//   stream     : byte/codeword handshake bundle (slave side)
//   cnt_clr    : synchronous clear of word_cnt (wins over an increment)
//   word_cnt   : number of output handshakes, saturating at all-ones
// -----------------------------------------------------------------------------
module hamming_encoder_stream
  import hamming_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  hamming_encoder_stream_if.slave stream,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       word_cnt
);

  logic [CODE_W-1:0]           inj_mask;
  logic [CODE_W-1:0]           enc_word;
  fifo_entry_t                 push_entry;
  fifo_entry_t                 head_entry;
  logic [$clog2(FIFO_DEPTH):0] occupancy;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        in_fire;
  logic                        out_fire;
  logic [CNT_W-1:0]            word_cnt_reg;

  assign in_fire  = stream.in_valid && stream.in_ready;
  assign out_fire = stream.out_valid && stream.out_ready;

  // Out-of-range injection positions (12..15) leave the codeword untouched,
  // and the upper stored nibble is never reachable by the mask.
  always_comb begin
    inj_mask = '0;
    if (stream.inj_en && (stream.inj_pos <= 4'd11)) begin
      inj_mask = CODE_W'(1) << stream.inj_pos;
    end
  end

  always_comb begin
    enc_word        = hamming_encode12(stream.in_data) ^ inj_mask;
    push_entry.last = stream.in_last;
    push_entry.code = {{(STORE_W-CODE_W){1'b0}}, enc_word};
  end

  hamming_fifo2 #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_fire),
    .push_data (push_entry),
    .pop       (out_fire),
    .head      (head_entry),
    .occupancy (occupancy),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // in_ready depends only on the stored occupancy, never on out_ready, so a
  // pop from a full buffer opens the input on the following cycle.
  assign stream.in_ready  = !fifo_full;
  assign stream.out_valid = !fifo_empty;
  assign stream.out_data  = head_entry.code;
  assign stream.out_last  = head_entry.last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_reg <= '0;
    end else if (cnt_clr) begin
      word_cnt_reg <= '0;
    end else if (out_fire && (word_cnt_reg != '1)) begin
      word_cnt_reg <= word_cnt_reg + CNT_W'(1);
    end
  end

  assign word_cnt = word_cnt_reg;

  // Only consumed by the full/empty flags inside the buffer.
  logic unused_occ;
  assign unused_occ = ^occupancy;

endmodule

// File: tb/tb_hamming_encoder_stream.sv
// -----------------------------------------------------------------------------
// tb_hamming_encoder_stream
// Self-checking bench for hamming_encoder_stream: a table of known codewords,
// directed back-pressure / frame / counter / reset sequences and a random
// stream, all checked against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_hamming_encoder_stream;

  logic        clk;
  logic        rst_n;
  logic        cnt_clr;
  logic [15:0] word_cnt;

  hamming_encoder_stream_if ifc ();

  hamming_encoder_stream #(
    .FIFO_DEPTH (2),
    .CNT_W      (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stream   (ifc),
    .cnt_clr  (cnt_clr),
    .word_cnt (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Model state: buffered {last, codeword} entries and the delivered count.
  logic [16:0] model_q [$];
  int          cnt_m;

  typedef struct {
    logic [7:0]  data;
    logic        ie;
    logic [3:0]  ip;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference encoder from the Hamming position rule: data fills the
  // non-power-of-two positions 1..12 in order; parity at position 2^k covers
  // every position whose index has bit k set.
  function automatic logic [11:0] ref_encode(input logic [7:0] d, input logic ie,
                                             input logic [3:0] ip);
    logic [12:0] h;
    logic [11:0] r;
    int          k;
    h = '0;
    k = 0;
    for (int pos = 1; pos <= 12; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        h[pos] = d[k];
        k++;
      end
    end
    for (int pb = 0; pb < 4; pb++) begin
      logic par;
      par = 1'b0;
      for (int pos = 1; pos <= 12; pos++) begin
        if ((pos & (1 << pb)) != 0) par = par ^ h[pos];
      end
      h[1 << pb] = par;
    end
    for (int i = 0; i < 12; i++) r[i] = h[i + 1];
    if (ie && (ip < 12)) r[ip] = ~r[ip];
    return r;
  endfunction

  // One clock cycle: check outputs against the model, drive inputs, advance
  // across the rising edge, then update the model with the handshakes that
  // should have happened.
  task automatic cycle(input logic v, input logic [7:0] d, input logic l,
                       input logic ie, input logic [3:0] ip, input logic ordy,
                       input logic clr);
    logic exp_vld;
    logic exp_rdy;
    logic in_fire;
    logic out_fire;
    exp_vld = (model_q.size() != 0);
    exp_rdy = (model_q.size() < 2);
    chk("out_valid", 32'(ifc.out_valid), 32'(exp_vld));
    chk("in_ready", 32'(ifc.in_ready), 32'(exp_rdy));
    if (exp_vld) begin
      chk("out_data", 32'(ifc.out_data), 32'(model_q[0][15:0]));
      chk("out_last", 32'(ifc.out_last), 32'(model_q[0][16]));
    end
    chk("word_cnt", 32'(word_cnt), 32'(cnt_m));
    ifc.in_valid  = v;
    ifc.in_data   = d;
    ifc.in_last   = l;
    ifc.inj_en    = ie;
    ifc.inj_pos   = ip;
    ifc.out_ready = ordy;
    cnt_clr       = clr;
    in_fire  = v && exp_rdy;
    out_fire = exp_vld && ordy;
    @(posedge clk);
    #1;
    if (out_fire) void'(model_q.pop_front());
    if (in_fire) model_q.push_back({l, 4'b0000, ref_encode(d, ie, ip)});
    if (clr) cnt_m = 0;
    else if (out_fire && (cnt_m != 65535)) cnt_m++;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 4'd0, ordy, 1'b0);
  endtask

  initial begin
    int idx;
    int guard;
    logic [7:0] fb [4];
    logic [15:0] cw_a;
    logic [15:0] cw_b;
    logic [15:0] cw_c;

    vectors     = 0;
    miscompares = 0;
    cnt_m       = 0;

    tbl[0] = '{8'h00, 1'b0, 4'd0,  16'h0000};
    tbl[1] = '{8'h01, 1'b0, 4'd0,  16'h0007};
    tbl[2] = '{8'h80, 1'b0, 4'd0,  16'h0888};
    tbl[3] = '{8'hA5, 1'b0, 4'd0,  16'h0A27};
    tbl[4] = '{8'hFF, 1'b0, 4'd0,  16'h0F77};
    tbl[5] = '{8'hA5, 1'b1, 4'd5,  16'h0A07};
    tbl[6] = '{8'hA5, 1'b1, 4'd13, 16'h0A27};
    tbl[7] = '{8'h00, 1'b1, 4'd11, 16'h0800};

    // ---------------- reset state ----------------
    rst_n         = 1'b0;
    cnt_clr       = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = 8'h00;
    ifc.in_last   = 1'b0;
    ifc.inj_en    = 1'b0;
    ifc.inj_pos   = 4'd0;
    ifc.out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_out_data", 32'(ifc.out_data), 32'd0);
    chk("rst_out_last", 32'(ifc.out_last), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ---------------- table: known codewords, one-cycle latency ----------------
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, tbl[i].data, 1'b0, tbl[i].ie, tbl[i].ip, 1'b1, 1'b0);
      chk("tbl_latency_valid", 32'(ifc.out_valid), 32'd1);
      chk("tbl_code", 32'(ifc.out_data), 32'(tbl[i].exp));
      $display("vec %0d: data=0x%02h inj_en=%0d inj_pos=%0d -> code=0x%04h (want 0x%04h)",
               i, tbl[i].data, tbl[i].ie, tbl[i].ip, ifc.out_data, tbl[i].exp);
      idle(1'b1);
    end

    // ---------------- back-pressure ----------------
    cw_a = {4'b0, ref_encode(8'h11, 1'b0, 4'd0)};
    cw_b = {4'b0, ref_encode(8'h22, 1'b0, 4'd0)};
    cw_c = {4'b0, ref_encode(8'h33, 1'b0, 4'd0)};
    cycle(1'b1, 8'h11, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("bp_ready_after1", 32'(ifc.in_ready), 32'd1);
    cycle(1'b1, 8'h22, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("bp_ready_full", 32'(ifc.in_ready), 32'd0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("bp_held_head", 32'(ifc.out_data), 32'(cw_a));
    chk("bp_still_full", 32'(ifc.in_ready), 32'd0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    chk("bp_second_head", 32'(ifc.out_data), 32'(cw_b));
    chk("bp_ready_after_pop", 32'(ifc.in_ready), 32'd1);
    cycle(1'b1, 8'h33, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    chk("bp_third_head", 32'(ifc.out_data), 32'(cw_c));
    idle(1'b1);
    chk("bp_drained", 32'(ifc.out_valid), 32'd0);
    $display("backpressure: 0x%04h 0x%04h 0x%04h delivered in order", cw_a, cw_b, cw_c);

    // ---------------- frame marker through a stall ----------------
    fb[0] = 8'h10; fb[1] = 8'h20; fb[2] = 8'h30; fb[3] = 8'h40;
    idx   = 0;
    guard = 0;
    while ((idx < 4) && (guard < 20)) begin
      logic acc;
      acc = (model_q.size() < 2);
      cycle(1'b1, fb[idx], (idx == 3), 1'b0, 4'd0, (guard >= 4), 1'b0);
      if (acc) idx++;
      guard++;
    end
    chk("frame_all_accepted", 32'(idx), 32'd4);
    guard = 0;
    while ((model_q.size() != 0) && (guard < 10)) begin
      idle(1'b1);
      guard++;
    end
    chk("frame_drained", 32'(model_q.size()), 32'd0);
    $display("frame: 4 bytes, last on 4th, delivered after stall");

    // ---------------- random stream ----------------
    for (int i = 0; i < 1500; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), 4'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 49) == 0));
    end

    // ---------------- counter: clear, saturate, clear with handshake ----------------
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    chk("cnt_cleared", 32'(word_cnt), 32'd0);
    guard = 0;
    while ((cnt_m < 65534) && (guard < 70000)) begin
      cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      guard++;
    end
    chk("cnt_preload", 32'(word_cnt), 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    end
    chk("cnt_saturated", 32'(word_cnt), 32'hFFFF);
    cycle(1'b1, 8'h5A, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    chk("cnt_clr_wins", 32'(word_cnt), 32'd0);
    $display("counter: saturated at 0xFFFF, cleared to 0x%04h", word_cnt);
    guard = 0;
    while ((model_q.size() != 0) && (guard < 10)) begin
      idle(1'b1);
      guard++;
    end

    // ---------------- reset mid-stream at occupancy 2 ----------------
    cycle(1'b1, 8'hC3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    cycle(1'b1, 8'h3C, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    cycle(1'b1, 8'h99, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("pre_rst_full", 32'(ifc.in_ready), 32'd0);
    ifc.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(ifc.out_data), 32'd0);
    chk("mid_rst_out_last", 32'(ifc.out_last), 32'd0);
    chk("mid_rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("mid_rst_in_ready", 32'(ifc.in_ready), 32'd1);
    #2;
    rst_n = 1'b1;
    model_q.delete();
    cnt_m = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) idle(1'b1);
    $display("reset: mid-stream reset cleared buffer and counter");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
